// File: rtl/envelope.sv
// Streaming peak/trough envelope detector.
// A SIZE-deep sample window shifts one sample per clock. When the centre tap
// is the window extreme and differs strictly from its older neighbour, it is
// latched as the new peak or trough. dataout carries half the peak-to-peak span.
// Optional macro ENVELOPE_DECAY_EN: between detections the latched peak and
// trough creep one LSB per clock toward zero, so the envelope collapses when
// the input goes quiet.
module envelope #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] datain,
  output logic                    posen,
  output logic                    negen,
  output logic signed [WIDTH-1:0] dataout,
  output logic signed [WIDTH-1:0] maxout,
  output logic signed [WIDTH-1:0] minout
);

  localparam int C  = SIZE / 2;
  localparam int CW = $clog2(SIZE + 1);

  logic signed [WIDTH-1:0] w [SIZE];
  logic [CW-1:0]           fill;
  logic                    filled;

  logic signed [WIDTH-1:0] win_max;
  logic signed [WIDTH-1:0] win_min;
  logic signed [WIDTH-1:0] centre;
  logic signed [WIDTH-1:0] older;
  logic                    is_peak;
  logic                    is_trough;

  logic signed [WIDTH-1:0] next_max;
  logic signed [WIDTH-1:0] next_min;
  logic signed [WIDTH:0]   span;
  logic                    unused_span_lsb;

  assign filled          = (fill == CW'(SIZE));
  assign centre          = w[C];
  assign older           = w[C+1];
  assign unused_span_lsb = span[0];

  // Sample window: newest sample enters at w[0], everything else ages by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) begin
        w[i] <= '0;
      end
    end else begin
      w[0] <= datain;
      for (int i = 1; i < SIZE; i++) begin
        w[i] <= w[i-1];
      end
    end
  end

  // Fill counter saturates at SIZE; detection waits until the window holds only real samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill <= '0;
    end else if (!filled) begin
      fill <= fill + CW'(1);
    end
  end

  // Signed max/min over the whole window, combinational reduction.
  always_comb begin
    win_max = w[0];
    win_min = w[0];
    for (int i = 1; i < SIZE; i++) begin
      if (w[i] > win_max) win_max = w[i];
      if (w[i] < win_min) win_min = w[i];
    end
  end

  // Centre must be the window extreme and strictly beyond its older neighbour,
  // so a plateau fires once on its first sample and a flat input never fires.
  always_comb begin
    is_peak   = filled && (centre >= win_max) && (centre > older);
    is_trough = filled && (centre <= win_min) && (centre < older);
  end

  // Next latched extremes (with optional decay toward zero) and half span.
  always_comb begin
    next_max = maxout;
    next_min = minout;
    if (is_peak) begin
      next_max = centre;
    end
`ifdef ENVELOPE_DECAY_EN
    else if (filled && (maxout != '0)) begin
      next_max = maxout[WIDTH-1] ? (maxout + WIDTH'(1)) : (maxout - WIDTH'(1));
    end
`endif
    if (is_trough) begin
      next_min = centre;
    end
`ifdef ENVELOPE_DECAY_EN
    else if (filled && (minout != '0)) begin
      next_min = minout[WIDTH-1] ? (minout + WIDTH'(1)) : (minout - WIDTH'(1));
    end
`endif
    span = {next_max[WIDTH-1], next_max} - {next_min[WIDTH-1], next_min};
  end

  // Registered outputs: pulses, latched extremes and amplitude update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      posen   <= 1'b0;
      negen   <= 1'b0;
      maxout  <= '0;
      minout  <= '0;
      dataout <= '0;
    end else begin
      posen   <= is_peak;
      negen   <= is_trough;
      maxout  <= next_max;
      minout  <= next_min;
      dataout <= span[WIDTH:1];
    end
  end

endmodule

// File: tb/tb_envelope.sv
// Self-checking bench for envelope (WIDTH=16, SIZE=8).
// Expected values are hand-derived; decay-dependent expectations follow ENVELOPE_DECAY_EN.
module tb_envelope;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] datain = '0;
  logic               posen;
  logic               negen;
  logic signed [15:0] dataout;
  logic signed [15:0] maxout;
  logic signed [15:0] minout;

  int passed = 0;
  int total  = 0;

`ifdef ENVELOPE_DECAY_EN
  localparam bit DECAY = 1'b1;
`else
  localparam bit DECAY = 1'b0;
`endif

  envelope #(.WIDTH(16), .SIZE(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .datain  (datain),
    .posen   (posen),
    .negen   (negen),
    .dataout (dataout),
    .maxout  (maxout),
    .minout  (minout)
  );

  always #5 clk = ~clk;

  // Drive one sample, let it be captured, then sample outputs 1 time unit later.
  task automatic applyStimulus(input logic signed [15:0] v);
    datain = v;
    @(posedge clk);
    #1;
  endtask

  // Hold reset across an edge and release it away from the clock edge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic signed [15:0] ramp_val(input int idx);
    if (idx <= 20)      return 16'(2 * idx);
    else if (idx <= 55) return 16'(40 - 2 * (idx - 20));
    else                return 16'(-30 + 2 * (idx - 55));
  endfunction

  function automatic logic signed [15:0] sine_val(input int idx);
    int q [9] = '{0, 195, 383, 556, 707, 831, 924, 981, 1000};
    int k;
    k = idx % 32;
    if (k <= 8)       return 16'(q[k]);
    else if (k <= 16) return 16'(q[16 - k]);
    else if (k <= 24) return 16'(-q[k - 16]);
    else              return 16'(-q[32 - k]);
  endfunction

  task automatic test_reset();
    reset  = 1'b1;
    datain = 16'($urandom);
    #12;
    total++;
    if ({posen, negen, dataout, maxout, minout} !== 50'd0)
      $display("[TB] FAIL reset_outputs: got %b/%b/%0d/%0d/%0d expected all zero", posen, negen, dataout, maxout, minout);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    int pos_count = 0;
    int neg_count = 0;
    int pos_edge  = -1;
    int neg_edge  = -1;
    logic signed [15:0] exp_max;
    logic signed [15:0] exp_data;
    for (int idx = 0; idx <= 70; idx++) begin
      applyStimulus(ramp_val(idx));
      if (posen) begin pos_count++; pos_edge = idx; end
      if (negen) begin neg_count++; neg_edge = idx; end
      if (idx == 25) begin
        total++;
        if (maxout !== 16'sd40) $display("[TB] FAIL ramp_peak_maxout: got %0d expected 40", maxout);
        else passed++;
        total++;
        if (dataout !== 16'sd20) $display("[TB] FAIL ramp_peak_dataout: got %0d expected 20", dataout);
        else passed++;
      end
      if (idx == 60) begin
        exp_max  = DECAY ? 16'sd5 : 16'sd40;
        exp_data = DECAY ? 16'sd17 : 16'sd35;
        total++;
        if (minout !== -16'sd30) $display("[TB] FAIL ramp_trough_minout: got %0d expected -30", minout);
        else passed++;
        total++;
        if (dataout !== exp_data) $display("[TB] FAIL ramp_trough_dataout: got %0d expected %0d", dataout, exp_data);
        else passed++;
        total++;
        if (maxout !== exp_max) $display("[TB] FAIL ramp_trough_maxout: got %0d expected %0d", maxout, exp_max);
        else passed++;
      end
    end
    total++;
    if (pos_count != 1) $display("[TB] FAIL ramp_pos_count: got %0d expected 1", pos_count);
    else passed++;
    total++;
    if (pos_edge != 25) $display("[TB] FAIL ramp_pos_edge: got %0d expected 25", pos_edge);
    else passed++;
    total++;
    if (neg_count != 1) $display("[TB] FAIL ramp_neg_count: got %0d expected 1", neg_count);
    else passed++;
    total++;
    if (neg_edge != 60) $display("[TB] FAIL ramp_neg_edge: got %0d expected 60", neg_edge);
    else passed++;
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    #3;
    reset = 1'b1;
    #1;
    total++;
    if ({posen, negen, dataout, maxout, minout} !== 50'd0)
      $display("[TB] FAIL async_reset_outputs: got %b/%b/%0d/%0d/%0d expected all zero", posen, negen, dataout, maxout, minout);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int idx = 0; idx < 12; idx++) begin
      applyStimulus((idx == 0) ? 16'sd50 : 16'sd0);
      if (posen || negen) pulses++;
    end
    total++;
    if (pulses != 0) $display("[TB] FAIL post_reset_pulses: got %0d expected 0", pulses);
    else passed++;
  endtask

  task automatic test_constant();
    int pulses = 0;
    do_reset();
    for (int idx = 0; idx < 58; idx++) begin
      applyStimulus(16'sd100);
      if (posen || negen) pulses++;
    end
    total++;
    if (pulses != 0) $display("[TB] FAIL constant_pulses: got %0d expected 0", pulses);
    else passed++;
    total++;
    if ({dataout, maxout, minout} !== 48'd0)
      $display("[TB] FAIL constant_hold: got %0d/%0d/%0d expected 0/0/0", dataout, maxout, minout);
    else passed++;
  endtask

  task automatic test_sine();
    int pos_count = 0;
    int neg_count = 0;
    logic signed [15:0] exp_max;
    logic signed [15:0] exp_min;
    logic signed [15:0] exp_data;
    do_reset();
    for (int idx = 0; idx < 128; idx++) begin
      applyStimulus(sine_val(idx));
      if (posen) begin
        pos_count++;
        total++;
        if ((idx % 32) != 13) $display("[TB] FAIL sine_pos_phase: got edge %0d expected 13 mod 32", idx);
        else passed++;
      end
      if (negen) begin
        neg_count++;
        total++;
        if ((idx % 32) != 29) $display("[TB] FAIL sine_neg_phase: got edge %0d expected 29 mod 32", idx);
        else passed++;
      end
      if (idx == 13) begin
        total++;
        if (dataout !== 16'sd500) $display("[TB] FAIL sine_first_dataout: got %0d expected 500", dataout);
        else passed++;
      end
    end
    exp_max  = DECAY ? 16'sd982 : 16'sd1000;
    exp_min  = DECAY ? -16'sd998 : -16'sd1000;
    exp_data = DECAY ? 16'sd990 : 16'sd1000;
    total++;
    if (pos_count != 4) $display("[TB] FAIL sine_pos_count: got %0d expected 4", pos_count);
    else passed++;
    total++;
    if (neg_count != 4) $display("[TB] FAIL sine_neg_count: got %0d expected 4", neg_count);
    else passed++;
    total++;
    if (maxout !== exp_max) $display("[TB] FAIL sine_maxout: got %0d expected %0d", maxout, exp_max);
    else passed++;
    total++;
    if (minout !== exp_min) $display("[TB] FAIL sine_minout: got %0d expected %0d", minout, exp_min);
    else passed++;
    total++;
    if (dataout !== exp_data) $display("[TB] FAIL sine_dataout: got %0d expected %0d", dataout, exp_data);
    else passed++;
  endtask

  task automatic test_plateau();
    int pos_count = 0;
    int pos_edge  = -1;
    int step_n;
    logic signed [15:0] v;
    logic signed [15:0] exp_max;
    logic signed [15:0] exp_data;
    do_reset();
    for (int idx = 0; idx <= 35; idx++) begin
      case (idx)
        8:        v = 16'sd5;
        9, 10, 11: v = 16'sd9;
        12:       v = 16'sd3;
        default:  v = 16'sd0;
      endcase
      applyStimulus(v);
      if (posen) begin pos_count++; pos_edge = idx; end
      if (idx >= 14) begin
        step_n  = idx - 14;
        exp_max = DECAY ? ((step_n < 9) ? 16'(9 - step_n) : 16'sd0) : 16'sd9;
        total++;
        if (maxout !== exp_max) $display("[TB] FAIL plateau_maxout_e%0d: got %0d expected %0d", idx, maxout, exp_max);
        else passed++;
      end
    end
    exp_data = DECAY ? 16'sd0 : 16'sd4;
    total++;
    if (pos_count != 1) $display("[TB] FAIL plateau_pos_count: got %0d expected 1", pos_count);
    else passed++;
    total++;
    if (pos_edge != 14) $display("[TB] FAIL plateau_pos_edge: got %0d expected 14", pos_edge);
    else passed++;
    total++;
    if (dataout !== exp_data) $display("[TB] FAIL plateau_dataout: got %0d expected %0d", dataout, exp_data);
    else passed++;
  endtask

  // Run scenarios in order; ramp must follow the initial reset directly.
  initial begin
    test_reset();
    test_ramp();
    test_async_reset();
    test_constant();
    test_sine();
    test_plateau();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/envelope.md
Name: envelope

Overview:
Streaming peak/trough envelope detector for a signed sample stream, such as the output of the sine_cos oscillator.
- Shifts one sample per clock into a SIZE-deep window.
- Detects local maxima and minima at the window centre and latches them as maxout/minout.
- Pulses posen/negen on each detection.
- Outputs half the peak-to-peak amplitude on dataout.

Parameters:
WIDTH, 16, sample width in bits; all data ports are two's-complement signed.
SIZE, 8, window depth in samples; legal range 3..64; centre tap index C = SIZE/2 (integer division).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
datain  input  WIDTH  signed sample, taken every clock
posen  output  1  one-cycle pulse: positive peak latched into maxout
negen  output  1  one-cycle pulse: negative peak latched into minout
dataout  output  WIDTH  envelope amplitude = (maxout - minout) >>> 1
maxout  output  WIDTH  most recent positive peak value
minout  output  WIDTH  most recent negative peak value

Behaviour:
- Reset (asynchronous, active-high): window w[0..SIZE-1], fill counter, posen, negen, dataout, maxout and minout all go to 0. Reset asserted mid-stream discards all history.
- Each rising edge, window shift: w[0] <= datain and w[i] <= w[i-1]. w[0] is the newest sample; w[SIZE-1] is the oldest.
- Fill counter: saturates at SIZE. Detection is disabled until the counter equals SIZE, so there are no pulses for the first SIZE clocks after reset.
- Centre c = w[C] and older neighbour o = w[C+1]. All comparisons are signed.
- Peak condition: c >= every w[i] in the window AND c > o.
- Trough condition: c <= every w[i] in the window AND c < o.
  - The strict test against o makes a flat plateau fire exactly once, on its first sample.
  - A constant input never fires.
- Registered outputs on the edge where a condition is true:
  - posen <= 1 and maxout <= c for a peak; negen <= 1 and minout <= c for a trough.
  - Otherwise posen/negen <= 0 and maxout/minout hold.
  - Both conditions can hold together only if the whole window equals c, which the strict test on o excludes. No simultaneous pulses.
- Latency: a sample captured at edge n is at w[C] after edge n+C. posen/negen and maxout/minout update at edge n+C+1.
- dataout: registered on the same edge as maxout/minout, computed from the next-state max and min values. Subtraction is done at WIDTH+1 bits, then arithmetic shift right by 1, then truncation to WIDTH bits. No saturation is needed because the result always fits.
- The max/min reduction over the window may be a combinational tree or a pipelined tree. The latency above is mandatory, so any pipelining must be compensated by delaying the centre tap.

Optional Feature:
ENVELOPE_DECAY_EN
- Defined: on every post-fill clock with no posen, maxout moves 1 LSB toward 0 if nonzero. On every post-fill clock with no negen, minout moves 1 LSB toward 0 if nonzero. dataout tracks the decayed values on the same edge. The envelope therefore collapses when the signal disappears.
- Undefined: maxout/minout hold indefinitely between detections; no decay logic is synthesized.

Test Plan:
- Reset: assert reset mid-clock with arbitrary datain -> all outputs 0 immediately (asynchronous); no posen/negen during the first 8 clocks after release.
- Ramp 0,2,4,...,40 then 38,36,...,0 (WIDTH=16, SIZE=8), sample 40 captured at edge n -> posen=1 for exactly one cycle after edge n+5, maxout=40, dataout=20.
- Continue with the descent to -30 and back up -> negen one cycle, minout=-30 (0xFFE2), dataout=(40+30)>>>1=35; maxout stays 40.
- Constant 100 for 50 clocks after fill -> posen=negen=0 throughout; outputs hold their prior values.
- Sine, amplitude 1000, period 32 -> posen and negen each once per 32 clocks, 16 clocks apart; maxout=1000, minout=-1000, dataout=1000.
- Plateau 5,9,9,9,3 -> single posen, with maxout=9 latched from the first 9; with ENVELOPE_DECAY_EN defined, input held at 0 afterward -> maxout decrements 9,8,...,0, one step per clock, then holds at 0.
